// File: rtl/mult_ctrl_pkg.sv
// Shared types and width helpers for the shift-add multiplier sequencer.
// Signed operation is selected by the MULT_SIGNED_EN macro (see the datapath and top).
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } mult_state_e;

    localparam int DEFAULT_DW = 16;

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result bundle for the shift-add multiplier. Handshakes: an operand pair is taken
// when start=1 in IDLE (busy=0); a product transfers on a cycle with product_valid && product_ready.
interface shift_add_mult_ctrl_if #(
    parameter int DATA_WIDTH = mult_ctrl_pkg::DEFAULT_DW
);
    localparam int PROD_W = mult_ctrl_pkg::prod_w(DATA_WIDTH);
    localparam int CW     = mult_ctrl_pkg::cnt_w(DATA_WIDTH);

    logic                     start;
    logic [DATA_WIDTH-1:0]    multiplicand;
    logic [DATA_WIDTH-1:0]    multiplier;
    logic                     abort;
    logic                     busy;
    logic [CW-1:0]            pp_count;
    logic [PROD_W-1:0]        product;
    logic                     product_valid;
    logic                     product_ready;
    mult_ctrl_pkg::mult_state_e state;

    modport slave (
        input  start, multiplicand, multiplier, abort, product_ready,
        output busy, pp_count, product, product_valid, state
    );

    modport master (
        output start, multiplicand, multiplier, abort, product_ready,
        input  busy, pp_count, product, product_valid, state
    );
endinterface

// File: rtl/shift_add_mult_ctrl_datapath.sv
// Accumulator with shifted add/subtract of one partial product per enabled cycle.
// MULT_SIGNED_EN selects sign extension of the partial product.
module mult_pp_datapath
    import mult_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DW,
    localparam int PW = prod_w(DATA_WIDTH),
    localparam int CW = cnt_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  sub,
    input  logic [CW-1:0]         shamt,
    input  logic [DATA_WIDTH-1:0] pp,
    output logic [PW-1:0]         acc,
    output logic [PW-1:0]         acc_next
);
    logic [PW-1:0] ext;
    logic [PW-1:0] shifted;

`ifdef MULT_SIGNED_EN
    assign ext = {{DATA_WIDTH{pp[DATA_WIDTH-1]}}, pp};
`else
    assign ext = {{DATA_WIDTH{1'b0}}, pp};
`endif

    assign shifted  = ext << shamt;
    assign acc_next = sub ? (acc - shifted) : (acc + shifted);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the iterative shift-add multiplier: FSM, iteration counter, operand and
// product registers. MULT_SIGNED_EN makes the last iteration subtract (two's complement).
module shift_add_mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DW
) (
    input logic                 clk,
    input logic                 reset,
    shift_add_mult_ctrl_if.slave bus
);
    localparam int PW = prod_w(DATA_WIDTH);
    localparam int CW = cnt_w(DATA_WIDTH);

    mult_state_e state, state_next;
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [CW-1:0]         cnt;
    logic [PW-1:0]         product_q, acc, acc_next;
    logic                  last_iter;
    logic                  accept;
    logic                  sub;
    logic [DATA_WIDTH-1:0] pp;

    assign accept    = (state == IDLE) && bus.start && !bus.abort;
    assign last_iter = (state == RUN) && (cnt == CW'(DATA_WIDTH - 1));
    assign pp        = op_b[cnt] ? op_a : '0;

`ifdef MULT_SIGNED_EN
    assign sub = last_iter;
`else
    assign sub = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (last_iter) state_next = DONE;
            DONE: if (bus.product_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Cancel wins over every other transition once an operation is in flight.
        if (bus.abort && state != IDLE) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_a <= bus.multiplicand;
                op_b <= bus.multiplier;
            end
            if (bus.abort || state == LOAD || last_iter) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + CW'(1);
            end
            // The final partial product is folded in here so DONE shows the full result at once.
            if (last_iter && !bus.abort) begin
                product_q <= acc_next;
            end
        end
    end

    mult_pp_datapath #(.DATA_WIDTH(DATA_WIDTH)) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == LOAD),
        .en       (state == RUN),
        .sub      (sub),
        .shamt    (cnt),
        .pp       (pp),
        .acc      (acc),
        .acc_next (acc_next)
    );

    assign bus.busy          = (state != IDLE);
    assign bus.pp_count      = cnt;
    assign bus.product       = product_q;
    assign bus.product_valid = (state == DONE);
    assign bus.state         = state;
endmodule
